regfile16: RTL and testbench

Sixteen-entry, WIDTH-bit register file with one synchronous write port and two combinational read ports. Storage is a bank of enabled flip-flop words selected by a 4:16 write decoder. Each read port is built from WIDTH bit-slice 16:1 multiplexers: for bit b, input i of the slice is bit b of register i. The block feeds the operand buses of the datapath. Operand B is muxed downstream against immediates.

---
 rtl/regfile16_if.sv | 23 ++
 rtl/regfile16.sv | 92 +++++++++
 tb/tb_regfile16.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/regfile16_if.sv
// Register-file port bundle: one write port and two read ports.
// master drives indices and write data; slave returns read data.
interface regfile16_if #(
    parameter int WIDTH = 64
);
    logic             RegWrite;
    logic [3:0]       WriteRegister;
    logic [WIDTH-1:0] WriteData;
    logic [3:0]       ReadRegister1;
    logic [3:0]       ReadRegister2;
    logic [WIDTH-1:0] ReadData1;
    logic [WIDTH-1:0] ReadData2;

    modport master (
        output RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
        input  ReadData1, ReadData2
    );

    modport slave (
        input  RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
        output ReadData1, ReadData2
    );
endinterface

// File: rtl/regfile16.sv
// Sixteen-entry register file: decoded synchronous write port, two combinational
// bit-slice 16:1 read ports, optional hard-zero R15 and optional write bypass.
module regfile16 #(
    parameter int WIDTH    = 64,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 0
) (
    input  logic       clk,
    input  logic       reset,
    regfile16_if.slave bus
);

    logic [WIDTH-1:0] regs [16];
    logic [15:0]      write_en;
    logic [15:0]      slice [WIDTH];
    logic [WIDTH-1:0] read_data1;
    logic [WIDTH-1:0] read_data2;
    logic             hit1;
    logic             hit2;

    // 4:16 decoder gated by RegWrite; a hard-zero R15 never sees an enable.
    always_comb begin
        write_en = '0;
        if (bus.RegWrite) begin
            write_en[bus.WriteRegister] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            write_en[15] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (write_en[i]) begin
                    regs[i] <= bus.WriteData;
                end
            end
        end
    end

    // Transpose storage so each output bit is a 16:1 mux over one register bit column.
    always_comb begin
        for (int b = 0; b < WIDTH; b++) begin
            for (int i = 0; i < 16; i++) begin
                slice[b][i] = regs[i][b];
            end
            if (ZERO_REG != 0) begin
                slice[b][15] = 1'b0;
            end
        end
    end

    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        if (BYPASS != 0 && bus.RegWrite && !reset) begin
            hit1 = (bus.ReadRegister1 == bus.WriteRegister) &&
                   !(ZERO_REG != 0 && bus.ReadRegister1 == 4'd15);
            hit2 = (bus.ReadRegister2 == bus.WriteRegister) &&
                   !(ZERO_REG != 0 && bus.ReadRegister2 == 4'd15);
        end
    end

    // Reset forces both buses low so nothing leaks through the bypass path.
    always_comb begin
        read_data1 = '0;
        read_data2 = '0;
        for (int b = 0; b < WIDTH; b++) begin
            read_data1[b] = slice[b][bus.ReadRegister1];
            read_data2[b] = slice[b][bus.ReadRegister2];
        end
        if (hit1) begin
            read_data1 = bus.WriteData;
        end
        if (hit2) begin
            read_data2 = bus.WriteData;
        end
        if (reset) begin
            read_data1 = '0;
            read_data2 = '0;
        end
    end

    assign bus.ReadData1 = read_data1;
    assign bus.ReadData2 = read_data2;

endmodule

// File: tb/tb_regfile16.sv
// Directed scoreboard bench for regfile16: one instance without bypass and one
// with bypass, both with hard-zero R15, driven by identical stimulus.
module tb_regfile16;

    localparam int          WIDTH = 64;
    localparam logic [63:0] STEP  = 64'h0101_0101_0101_0101;
    localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] NEWV  = 64'hDEAD_BEEF_0000_0005;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        reg_write = 1'b0;
    logic [3:0]  write_register = '0;
    logic [63:0] write_data = '0;
    logic [3:0]  read_register1 = '0;
    logic [3:0]  read_register2 = '0;

    regfile16_if #(.WIDTH(WIDTH)) bus_nb ();
    regfile16_if #(.WIDTH(WIDTH)) bus_bp ();

    assign bus_nb.RegWrite      = reg_write;
    assign bus_nb.WriteRegister = write_register;
    assign bus_nb.WriteData     = write_data;
    assign bus_nb.ReadRegister1 = read_register1;
    assign bus_nb.ReadRegister2 = read_register2;
    assign bus_bp.RegWrite      = reg_write;
    assign bus_bp.WriteRegister = write_register;
    assign bus_bp.WriteData     = write_data;
    assign bus_bp.ReadRegister1 = read_register1;
    assign bus_bp.ReadRegister2 = read_register2;

    regfile16 #(.WIDTH(WIDTH), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_nb.slave)
    );

    regfile16 #(.WIDTH(WIDTH), .ZERO_REG(1), .BYPASS(1)) dut_bp (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_bp.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          port;
        logic [63:0] value;
    } expect_t;

    expect_t scoreboard[$];
    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    task automatic applyStimulus(input logic we, input logic [3:0] wr, input logic [63:0] wd,
                                 input logic [3:0] r1, input logic [3:0] r2);
        reg_write      = we;
        write_register = wr;
        write_data     = wd;
        read_register1 = r1;
        read_register2 = r2;
    endtask

    // Ports: 0/1 = no-bypass read 1/2, 2/3 = bypass read 1/2.
    task automatic expectAll(input string tag, input logic [63:0] nb1, input logic [63:0] nb2,
                             input logic [63:0] bp1, input logic [63:0] bp2);
        scoreboard.push_back('{tag, 0, nb1});
        scoreboard.push_back('{tag, 1, nb2});
        scoreboard.push_back('{tag, 2, bp1});
        scoreboard.push_back('{tag, 3, bp2});
    endtask

    function automatic logic [63:0] observed(input int port);
        case (port)
            0:       return bus_nb.ReadData1;
            1:       return bus_nb.ReadData2;
            2:       return bus_bp.ReadData1;
            default: return bus_bp.ReadData2;
        endcase
    endfunction

    task automatic checkOutput();
        expect_t     e;
        logic [63:0] obs;
        #1;
        while (scoreboard.size() > 0) begin
            e   = scoreboard.pop_front();
            obs = observed(e.port);
            checkCount++;
            assert (obs === e.value) passCount++;
            else begin
                failCount++;
                $error("[TB] FAIL %s port%0d: observed %h expected %h", e.tag, e.port, obs, e.value);
            end
        end
    endtask

    initial begin
        applyStimulus(1'b0, 4'd0, '0, 4'd7, 4'd0);
        repeat (2) @(negedge clk);
        expectAll("reset_hold", '0, '0, '0, '0);
        checkOutput();
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            applyStimulus(1'b0, 4'(i), ONES, 4'(i), 4'(15 - i));
            expectAll("reset_read", '0, '0, '0, '0);
            checkOutput();
        end

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            applyStimulus(1'b1, 4'(i), STEP * 64'(i), 4'd0, 4'd0);
        end
        @(negedge clk);
        applyStimulus(1'b0, 4'd0, '0, 4'd0, 4'd0);

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            applyStimulus(1'b0, 4'd0, '0, 4'(i), 4'(14 - i));
            expectAll("pair_read", STEP * 64'(i), STEP * 64'(14 - i),
                      STEP * 64'(i), STEP * 64'(14 - i));
            checkOutput();
        end

        @(negedge clk);
        applyStimulus(1'b1, 4'd15, ONES, 4'd15, 4'd15);
        expectAll("r15_bypass", '0, '0, '0, '0);
        checkOutput();
        @(posedge clk);
        expectAll("r15_after", '0, '0, '0, '0);
        checkOutput();

        @(negedge clk);
        applyStimulus(1'b1, 4'd0, ONES, 4'd0, 4'd15);
        expectAll("r0_before", '0, '0, ONES, '0);
        checkOutput();
        @(posedge clk);
        expectAll("r0_after", ONES, '0, ONES, '0);
        checkOutput();

        @(negedge clk);
        applyStimulus(1'b1, 4'd5, 64'h1234, 4'd0, 4'd0);
        @(negedge clk);
        applyStimulus(1'b1, 4'd5, NEWV, 4'd5, 4'd5);
        expectAll("r5_before", 64'h1234, 64'h1234, NEWV, NEWV);
        checkOutput();
        @(posedge clk);
        expectAll("r5_after", NEWV, NEWV, NEWV, NEWV);
        checkOutput();

        @(negedge clk);
        applyStimulus(1'b0, 4'd3, 64'hAAAA, 4'd3, 4'd3);
        repeat (3) begin
            @(posedge clk);
            expectAll("r3_hold", STEP * 64'd3, STEP * 64'd3, STEP * 64'd3, STEP * 64'd3);
            checkOutput();
        end

        @(negedge clk);
        applyStimulus(1'b1, 4'd7, 64'h77, 4'd7, 4'd7);
        @(posedge clk);
        expectAll("r7_load", 64'h77, 64'h77, 64'h77, 64'h77);
        checkOutput();

        // Reset lands mid-cycle with a write to R7 pending.
        @(negedge clk);
        applyStimulus(1'b1, 4'd7, 64'h99, 4'd7, 4'd7);
        #2;
        reset = 1'b1;
        expectAll("reset_midcycle", '0, '0, '0, '0);
        checkOutput();
        @(posedge clk);
        expectAll("reset_edge_write", '0, '0, '0, '0);
        checkOutput();

        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b0, 4'd7, 64'h99, 4'd7, 4'd7);
        expectAll("write_lost", '0, '0, '0, '0);
        checkOutput();

        @(negedge clk);
        applyStimulus(1'b1, 4'd7, 64'h55, 4'd7, 4'd2);
        expectAll("post_reset_before", '0, '0, 64'h55, '0);
        checkOutput();
        @(posedge clk);
        expectAll("post_reset_after", 64'h55, '0, 64'h55, '0);
        checkOutput();

        @(negedge clk);
        applyStimulus(1'b0, 4'd0, '0, 4'd0, 4'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
